// File: rtl/decoupled_queue_param_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decoupled_queue_param_pkg                                            |
// | Width helpers shared by the parametrised ready/valid queue.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package decoupled_queue_param_pkg;

    localparam int DEFAULT_WIDTH = 55;
    localparam int DEFAULT_DEPTH = 2;

    // Pointer width never collapses to zero bits, even for tiny depths.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Occupancy spans 0..DEPTH inclusive, hence one extra code point.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoupled_queue_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decoupled_queue_param_if                                             |
// | Enqueue/dequeue handshake, flush and occupancy bundle.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface decoupled_queue_param_if
    import decoupled_queue_param_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int CW = count_width(DEPTH);

    logic             flush;
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_bits;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_bits;
    logic [CW-1:0]    count;

    modport master (
        output flush, enq_valid, enq_bits, deq_ready,
        input  enq_ready, deq_valid, deq_bits, count
    );

    modport slave (
        input  flush, enq_valid, enq_bits, deq_ready,
        output enq_ready, deq_valid, deq_bits, count
    );

endinterface
`default_nettype wire

// File: rtl/decoupled_queue_param_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | queue_ram                                                            |
// | Queue storage: one synchronous write port, one async read port.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module queue_ram
    import decoupled_queue_param_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = clog2_min1(DEPTH)
) (
    input  wire logic [AW-1:0]    W0_addr,
    input  wire logic             W0_en,
    input  wire logic             W0_clk,
    input  wire logic [WIDTH-1:0] W0_data,
    input  wire logic [AW-1:0]    R0_addr,
    input  wire logic             R0_en,
    input  wire logic             R0_clk,
    output logic      [WIDTH-1:0] R0_data
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             unused_r0_clk;

    // The read port is combinational; its clock exists only for macro compatibility.
    assign unused_r0_clk = R0_clk;

    always_ff @(posedge W0_clk) begin
        if (W0_en) begin
            mem_q[W0_addr] <= W0_data;
        end
    end

    assign R0_data = R0_en ? mem_q[R0_addr] : {WIDTH{1'bx}};

endmodule
`default_nettype wire

// File: rtl/decoupled_queue_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decoupled_queue_param                                                |
// | Ready/valid FIFO with optional PIPE/FLOW modes, count and flush.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module decoupled_queue_param
    import decoupled_queue_param_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PIPE  = 0,
    parameter int FLOW  = 0
) (
    input  wire logic               clock,
    input  wire logic               reset_n,
    decoupled_queue_param_if.slave  q
);
    localparam int PW      = clog2_min1(DEPTH);
    localparam int CW      = count_width(DEPTH);
    localparam bit PIPE_EN = (PIPE != 0);
    localparam bit FLOW_EN = (FLOW != 0);

    logic [PW-1:0]    enq_ptr_q, enq_ptr_d;
    logic [PW-1:0]    deq_ptr_q, deq_ptr_d;
    logic             maybe_full_q, maybe_full_d;
    logic             match, empty, full;
    logic             do_enq, do_deq, bypass_take;
    logic             int_enq, int_deq;
    logic [PW-1:0]    ptr_diff;
    logic [WIDTH-1:0] ram_rdata;

    always_comb begin
        match       = (enq_ptr_q == deq_ptr_q);
        empty       = match && !maybe_full_q;
        full        = match && maybe_full_q;
        q.enq_ready = !q.flush && (!full || (PIPE_EN && q.deq_ready));
        q.deq_valid = !q.flush && (!empty || (FLOW_EN && q.enq_valid));
        do_enq      = q.enq_valid && q.enq_ready;
        do_deq      = q.deq_valid && q.deq_ready;
        // A bypassed beat goes straight through, so storage must stay untouched.
        bypass_take = FLOW_EN && empty && q.deq_ready;
        int_enq     = do_enq && !bypass_take;
        int_deq     = do_deq && !bypass_take;
        q.deq_bits  = (FLOW_EN && empty) ? q.enq_bits : ram_rdata;
    end

    always_comb begin
        enq_ptr_d    = enq_ptr_q;
        deq_ptr_d    = deq_ptr_q;
        maybe_full_d = maybe_full_q;
        if (q.flush) begin
            enq_ptr_d    = '0;
            deq_ptr_d    = '0;
            maybe_full_d = 1'b0;
        end else begin
            if (int_enq) enq_ptr_d = enq_ptr_q + PW'(1);
            if (int_deq) deq_ptr_d = deq_ptr_q + PW'(1);
            if (int_enq != int_deq) maybe_full_d = int_enq;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enq_ptr_q    <= '0;
            deq_ptr_q    <= '0;
            maybe_full_q <= 1'b0;
        end else begin
            enq_ptr_q    <= enq_ptr_d;
            deq_ptr_q    <= deq_ptr_d;
            maybe_full_q <= maybe_full_d;
        end
    end

    // Difference is taken at pointer width so it wraps modulo DEPTH before widening.
    assign ptr_diff = enq_ptr_q - deq_ptr_q;
    assign q.count  = full ? CW'(DEPTH) : CW'(ptr_diff);

    queue_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .W0_addr (enq_ptr_q),
        .W0_en   (int_enq),
        .W0_clk  (clock),
        .W0_data (q.enq_bits),
        .R0_addr (deq_ptr_q),
        .R0_en   (1'b1),
        .R0_clk  (clock),
        .R0_data (ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_decoupled_queue_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_decoupled_queue_param                                             |
// | Three queue configurations driven in lockstep against a FIFO model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_decoupled_queue_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       enq_valid;
    logic [7:0] enq_bits;
    logic       deq_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Instance 0: D4 plain, instance 1: D2 PIPE, instance 2: D4 FLOW.
    decoupled_queue_param_if #(.WIDTH(8), .DEPTH(4)) if0 ();
    decoupled_queue_param_if #(.WIDTH(8), .DEPTH(2)) if1 ();
    decoupled_queue_param_if #(.WIDTH(8), .DEPTH(4)) if2 ();

    decoupled_queue_param #(.WIDTH(8), .DEPTH(4), .PIPE(0), .FLOW(0)) dut0 (
        .clock(clk), .reset_n(reset_n), .q(if0));
    decoupled_queue_param #(.WIDTH(8), .DEPTH(2), .PIPE(1), .FLOW(0)) dut1 (
        .clock(clk), .reset_n(reset_n), .q(if1));
    decoupled_queue_param #(.WIDTH(8), .DEPTH(4), .PIPE(0), .FLOW(1)) dut2 (
        .clock(clk), .reset_n(reset_n), .q(if2));

    assign if0.flush = flush;     assign if1.flush = flush;     assign if2.flush = flush;
    assign if0.enq_valid = enq_valid; assign if1.enq_valid = enq_valid; assign if2.enq_valid = enq_valid;
    assign if0.enq_bits = enq_bits;   assign if1.enq_bits = enq_bits;   assign if2.enq_bits = enq_bits;
    assign if0.deq_ready = deq_ready; assign if1.deq_ready = deq_ready; assign if2.deq_ready = deq_ready;

    logic       rdy [3];
    logic       vld [3];
    logic [7:0] bits[3];
    int         cnt [3];

    assign rdy[0] = if0.enq_ready;  assign rdy[1] = if1.enq_ready;  assign rdy[2] = if2.enq_ready;
    assign vld[0] = if0.deq_valid;  assign vld[1] = if1.deq_valid;  assign vld[2] = if2.deq_valid;
    assign bits[0] = if0.deq_bits;  assign bits[1] = if1.deq_bits;  assign bits[2] = if2.deq_bits;
    assign cnt[0] = int'(if0.count); assign cnt[1] = int'(if1.count); assign cnt[2] = int'(if2.count);

    always #5 clk = ~clk;

    // Reference model: occupancy plus an ordered list, head at index 0.
    logic [7:0] mbuf[3][4];
    int         mcnt[3];

    function automatic int md(input int i);
        return (i == 1) ? 2 : 4;
    endfunction
    function automatic bit mp(input int i);
        return (i == 1);
    endfunction
    function automatic bit mf(input int i);
        return (i == 2);
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit ev, input logic [7:0] eb, input bit dr, input bit fl);
        bit er, dv;
        @(negedge clk);
        enq_valid = ev;
        enq_bits  = eb;
        deq_ready = dr;
        flush     = fl;
        #1;
        for (int i = 0; i < 3; i++) begin
            er = !fl && ((mcnt[i] < md(i)) || (mp(i) && dr));
            dv = !fl && ((mcnt[i] > 0) || (mf(i) && ev));
            check_eq($sformatf("enq_ready[%0d]", i), int'(rdy[i]), int'(er));
            check_eq($sformatf("deq_valid[%0d]", i), int'(vld[i]), int'(dv));
            check_eq($sformatf("count[%0d]", i), cnt[i], mcnt[i]);
            if (dv)
                check_eq($sformatf("deq_bits[%0d]", i), int'(bits[i]),
                         int'((mcnt[i] > 0) ? mbuf[i][0] : eb));
        end
    endtask

    task automatic tick();
        bit er, pass_through;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            er = !flush && ((mcnt[i] < md(i)) || (mp(i) && deq_ready));
            pass_through = mf(i) && (mcnt[i] == 0) && deq_ready;
            if (flush) begin
                mcnt[i] = 0;
            end else if (!pass_through) begin
                if (deq_ready && mcnt[i] > 0) begin
                    for (int k = 0; k < 3; k++) mbuf[i][k] = mbuf[i][k+1];
                    mcnt[i]--;
                end
                if (enq_valid && er) begin
                    mbuf[i][mcnt[i]] = enq_bits;
                    mcnt[i]++;
                end
            end
        end
    endtask

    task automatic step(input bit ev, input logic [7:0] eb, input bit dr, input bit fl);
        drive(ev, eb, dr, fl);
        tick();
    endtask

    task automatic drain();
        for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        bit         rev, rdr, rfl;
        logic [7:0] rbits;
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
        reset_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_bits = 8'h00; deq_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("reset_enq_ready", int'(rdy[i]), 1);
            check_eq("reset_deq_valid", int'(vld[i]), 0);
            check_eq("reset_count", cnt[i], 0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        // Fill then drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
            check_eq("fill_count", cnt[0], i);
            tick();
        end
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        check_eq("full_enq_ready", int'(rdy[0]), 0);
        check_eq("full_count", cnt[0], 4);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            check_eq("drain_bits", int'(bits[0]), (i + 1) * 8'h11);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("drained_valid", int'(vld[0]), 0);
        check_eq("drained_count", cnt[0], 0);
        tick();

        // Wrap-around with one resident entry.
        step(1'b1, 8'hA0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0);
            check_eq("wrap_bits", int'(bits[0]), (i == 0) ? 8'hA0 : i - 1);
            check_eq("wrap_count", cnt[0], 1);
            tick();
        end
        drain();

        // PIPE accepts while full when the head leaves in the same cycle.
        step(1'b1, 8'h61, 1'b0, 1'b0);
        step(1'b1, 8'h62, 1'b0, 1'b0);
        drive(1'b1, 8'h63, 1'b1, 1'b0);
        check_eq("pipe_enq_ready", int'(rdy[1]), 1);
        check_eq("pipe_head", int'(bits[1]), 8'h61);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("pipe_count", cnt[1], 2);
        check_eq("pipe_new_head", int'(bits[1]), 8'h62);
        tick();
        drain();

        // FLOW bypass when empty.
        drive(1'b1, 8'h5A, 1'b1, 1'b0);
        check_eq("flow_valid", int'(vld[2]), 1);
        check_eq("flow_bits", int'(bits[2]), 8'h5A);
        check_eq("flow_count", cnt[2], 0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("flow_after_count", cnt[2], 0);
        check_eq("flow_after_valid", int'(vld[2]), 0);
        tick();
        drain();

        // Flush drops contents and the concurrent enqueue.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        drive(1'b1, 8'h77, 1'b0, 1'b1);
        check_eq("flush_enq_ready", int'(rdy[0]), 0);
        check_eq("flush_deq_valid", int'(vld[0]), 0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("post_flush_count", cnt[0], 0);
        check_eq("post_flush_valid", int'(vld[0]), 0);
        tick();

        // Asynchronous reset between edges.
        step(1'b1, 8'hB1, 1'b0, 1'b0);
        step(1'b1, 8'hB2, 1'b0, 1'b0);
        enq_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("async_rst_valid", int'(vld[i]), 0);
            check_eq("async_rst_ready", int'(rdy[i]), 1);
            check_eq("async_rst_count", cnt[i], 0);
            mcnt[i] = 0;
        end
        #1 reset_n = 1'b1;
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("post_rst_head", int'(bits[0]), 8'hC3);
        tick();
        drain();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rev   = ($urandom_range(0, 3) != 0);
            rdr   = ($urandom_range(0, 1) != 0);
            rfl   = ($urandom_range(0, 15) == 0);
            rbits = 8'($urandom);
            step(rev, rbits, rdr, rfl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
